// File: rtl/pi_spi_bridge.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pi_spi_bridge
// Turns SPI mode-0 command frames from the Raspberry Pi into single-byte bus
// requests for `main`, using a 4-phase pending/done handshake.
//
// Ports
//   clk16        16 MHz master clock (rising edge)
//   reset_b      asynchronous active-low reset
//   spi_sclk     SPI clock (mode 0), asynchronous
//   spi_cs_b     SPI chip select, active low, asynchronous
//   spi_mosi     SPI data in, asynchronous
//   spi_miso     SPI data out, changes on SCLK fall
//   pi_addr      bus request address
//   pi_rw_b      1 = read, 0 = write (idles at 1)
//   pi_data_out  write data
//   pi_data_in   read data returned by main
//   pi_pending   request valid
//   pi_done      request complete (clk16 domain)
//   spi_busy     a bus request is in flight
//   overrun      sticky: a request was dropped; clears on chip-select fall
// -----------------------------------------------------------------------------
module pi_spi_bridge (
    input  logic        clk16,
    input  logic        reset_b,
    input  logic        spi_sclk,
    input  logic        spi_cs_b,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [15:0] pi_addr,
    output logic        pi_rw_b,
    output logic [7:0]  pi_data_out,
    input  logic [7:0]  pi_data_in,
    output logic        pi_pending,
    input  logic        pi_done,
    output logic        spi_busy,
    output logic        overrun
);

    typedef enum logic [2:0] {
        F_CMD     = 3'd0,
        F_ADDR_HI = 3'd1,
        F_ADDR_LO = 3'd2,
        F_DATA    = 3'd3,
        F_IGNORE  = 3'd4
    } frame_state_t;

    typedef enum logic [1:0] {
        B_IDLE    = 2'd0,
        B_PEND    = 2'd1,
        B_RELEASE = 2'd2
    } bus_state_t;

    // Synchroniser stages: bit 0 is the metastability flop, bit 1 is stable.
    logic [1:0]   r_sclk_sync;
    logic [1:0]   r_cs_sync;
    logic [1:0]   r_mosi_sync;
    logic         r_sclk_prev;
    logic         r_cs_prev;

    logic         w_sclk_rise;
    logic         w_sclk_fall;
    logic         w_cs_b;
    logic         w_cs_fall;
    logic         w_mosi;
    logic         w_byte_done;
    logic [7:0]   w_byte;

    logic [2:0]   r_bit_cnt;
    logic [7:0]   r_rx;
    logic [7:0]   r_tx;

    frame_state_t r_fstate;
    frame_state_t w_fstate_next;
    logic [1:0]   r_cmd;
    logic         w_ld_cmd;
    logic         w_ld_hi;
    logic         w_ld_lo;
    logic         w_ld_data;
    logic         w_req;
    logic         w_req_rw;

    logic         r_req;
    logic         r_req_rw;
    logic [7:0]   r_wdata;
    logic [15:0]  r_addr;

    bus_state_t   r_bstate;
    bus_state_t   w_bstate_next;
    logic         w_accept;
    logic         w_complete;
    logic         w_release;
    logic         w_drop;

    logic [15:0]  r_pi_addr;
    logic         r_pi_rw_b;
    logic [7:0]   r_pi_data_out;
    logic         r_pi_pending;
    logic [7:0]   r_rd_data;
    logic         r_busy;
    logic         r_overrun;

    assign w_cs_b      = r_cs_sync[1];
    assign w_mosi      = r_mosi_sync[1];
    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_prev;
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_prev;
    assign w_cs_fall   = ~w_cs_b & r_cs_prev;
    // A byte completes on the 8th rise; a simultaneous chip-select rise wins.
    assign w_byte_done = w_sclk_rise & ~w_cs_b & (r_bit_cnt == 3'd7);
    assign w_byte      = {r_rx[6:0], w_mosi};

    // Two-flop synchronisers and edge-detect history for the SPI pins.
    always_ff @(posedge clk16 or negedge reset_b) begin
        if (!reset_b) begin
            r_sclk_sync <= 2'b00;
            r_cs_sync   <= 2'b11;
            r_mosi_sync <= 2'b00;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], spi_sclk};
            r_cs_sync   <= {r_cs_sync[0], spi_cs_b};
            r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
            r_sclk_prev <= r_sclk_sync[1];
            r_cs_prev   <= r_cs_sync[1];
        end
    end

    // SPI shift registers and bit counter.
    always_ff @(posedge clk16 or negedge reset_b) begin
        if (!reset_b) begin
            r_bit_cnt <= 3'd0;
            r_rx      <= 8'h00;
            r_tx      <= 8'h00;
        end else begin
            if (w_cs_b) begin
                r_bit_cnt <= 3'd0;
                r_rx      <= 8'h00;
            end else if (w_sclk_rise) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_rx      <= w_byte;
            end

            // The fall that follows the 8th rise must not shift: the freshly
            // loaded MSB is already on MISO for the next byte.
            if (w_cs_fall || w_byte_done) begin
                r_tx <= r_rd_data;
            end else if (w_sclk_fall && !w_cs_b && (r_bit_cnt != 3'd0)) begin
                r_tx <= {r_tx[6:0], 1'b0};
            end
        end
    end

    assign spi_miso = r_tx[7];

    // Frame FSM state register.
    always_ff @(posedge clk16 or negedge reset_b) begin
        if (!reset_b) begin
            r_fstate <= F_CMD;
        end else begin
            r_fstate <= w_fstate_next;
        end
    end

    // Frame FSM next-state and per-byte load/request decode.
    always_comb begin
        w_fstate_next = r_fstate;
        w_ld_cmd      = 1'b0;
        w_ld_hi       = 1'b0;
        w_ld_lo       = 1'b0;
        w_ld_data     = 1'b0;
        w_req         = 1'b0;
        w_req_rw      = 1'b1;
        if (w_cs_b) begin
            w_fstate_next = F_CMD;
        end else if (w_byte_done) begin
            case (r_fstate)
                F_CMD: begin
                    w_ld_cmd = 1'b1;
                    case (w_byte[7:6])
                        2'b00:   w_fstate_next = F_ADDR_HI;
                        2'b01:   w_fstate_next = F_ADDR_HI;
                        2'b10:   w_fstate_next = F_DATA;
                        2'b11: begin
                            w_req         = 1'b1;
                            w_req_rw      = 1'b1;
                            w_fstate_next = F_IGNORE;
                        end
                        default: w_fstate_next = F_CMD;
                    endcase
                end
                F_ADDR_HI: begin
                    w_ld_hi       = 1'b1;
                    w_fstate_next = F_ADDR_LO;
                end
                F_ADDR_LO: begin
                    w_ld_lo = 1'b1;
                    if (r_cmd == 2'b01) begin
                        w_req         = 1'b1;
                        w_req_rw      = 1'b1;
                        w_fstate_next = F_IGNORE;
                    end else begin
                        w_fstate_next = F_DATA;
                    end
                end
                F_DATA: begin
                    w_ld_data     = 1'b1;
                    w_req         = 1'b1;
                    w_req_rw      = 1'b0;
                    w_fstate_next = F_IGNORE;
                end
                F_IGNORE: w_fstate_next = F_IGNORE;
                default:  w_fstate_next = F_CMD;
            endcase
        end else begin
            w_fstate_next = r_fstate;
        end
    end

    // Command, write data, request strobe and the auto-incrementing address.
    always_ff @(posedge clk16 or negedge reset_b) begin
        if (!reset_b) begin
            r_cmd    <= 2'b00;
            r_wdata  <= 8'h00;
            r_req    <= 1'b0;
            r_req_rw <= 1'b1;
            r_addr   <= 16'h0000;
        end else begin
            r_req <= w_req;
            if (w_req) begin
                r_req_rw <= w_req_rw;
            end
            if (w_ld_cmd) begin
                r_cmd <= w_byte[7:6];
            end
            if (w_ld_data) begin
                r_wdata <= w_byte;
            end
            // A frame load takes priority over a completion increment.
            if (w_ld_hi) begin
                r_addr <= {w_byte, r_addr[7:0]};
            end else if (w_ld_lo) begin
                r_addr <= {r_addr[15:8], w_byte};
            end else if (w_complete) begin
                r_addr <= r_addr + 16'd1;
            end
        end
    end

    // Bus FSM state register.
    always_ff @(posedge clk16 or negedge reset_b) begin
        if (!reset_b) begin
            r_bstate <= B_IDLE;
        end else begin
            r_bstate <= w_bstate_next;
        end
    end

    // Bus FSM next-state and handshake event decode.
    always_comb begin
        w_bstate_next = r_bstate;
        w_accept      = 1'b0;
        w_complete    = 1'b0;
        w_release     = 1'b0;
        case (r_bstate)
            B_IDLE: begin
                if (r_req) begin
                    w_accept      = 1'b1;
                    w_bstate_next = B_PEND;
                end else begin
                    w_bstate_next = B_IDLE;
                end
            end
            B_PEND: begin
                if (pi_done) begin
                    w_complete    = 1'b1;
                    w_bstate_next = B_RELEASE;
                end else begin
                    w_bstate_next = B_PEND;
                end
            end
            B_RELEASE: begin
                if (!pi_done) begin
                    w_release     = 1'b1;
                    w_bstate_next = B_IDLE;
                end else begin
                    w_bstate_next = B_RELEASE;
                end
            end
            default: w_bstate_next = B_IDLE;
        endcase
    end

    assign w_drop = r_req & (r_bstate != B_IDLE);

    // Bus-side output registers, read data capture and overrun flag.
    always_ff @(posedge clk16 or negedge reset_b) begin
        if (!reset_b) begin
            r_pi_addr     <= 16'h0000;
            r_pi_rw_b     <= 1'b1;
            r_pi_data_out <= 8'h00;
            r_pi_pending  <= 1'b0;
            r_rd_data     <= 8'h00;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pi_addr     <= r_addr;
                r_pi_rw_b     <= r_req_rw;
                r_pi_data_out <= r_wdata;
                r_pi_pending  <= 1'b1;
            end
            if (w_complete) begin
                r_pi_pending <= 1'b0;
                if (r_pi_rw_b) begin
                    r_rd_data <= pi_data_in;
                end
            end
            if (w_release) begin
                r_pi_rw_b <= 1'b1;
            end
            r_busy <= (w_bstate_next != B_IDLE);
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (w_cs_fall) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign pi_addr     = r_pi_addr;
    assign pi_rw_b     = r_pi_rw_b;
    assign pi_data_out = r_pi_data_out;
    assign pi_pending  = r_pi_pending;
    assign spi_busy    = r_busy;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_pi_spi_bridge.sv
`timescale 1ns/1ps
// Testbench for pi_spi_bridge: SPI master driver, bus responder standing in
// for `main`, and a frame-level reference model of the address register and
// last read result.
module tb_pi_spi_bridge;

    localparam real SPI_HALF = 250.0;   // 2 MHz SCLK

    logic        clk16 = 1'b0;
    logic        reset_b = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_b = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [15:0] pi_addr;
    logic        pi_rw_b;
    logic [7:0]  pi_data_out;
    logic [7:0]  pi_data_in = 8'h00;
    logic        pi_pending;
    logic        pi_done = 1'b0;
    logic        spi_busy;
    logic        overrun;

    int checks = 0;
    int failures = 0;

    // Reference model state.
    logic [15:0] m_addr = 16'h0000;
    logic [7:0]  m_rd = 8'h00;

    // Responder control and captured requests.
    logic        resp_en = 1'b0;
    logic [7:0]  resp_val = 8'h00;
    int          resp_delay = 2;
    logic [15:0] q_addr[$];
    logic        q_rw[$];
    logic [7:0]  q_data[$];

    logic [7:0]  frame_q[$];
    logic [7:0]  first_rx;

    always #31.25 clk16 = ~clk16;

    pi_spi_bridge dut (
        .clk16       (clk16),
        .reset_b     (reset_b),
        .spi_sclk    (spi_sclk),
        .spi_cs_b    (spi_cs_b),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .pi_addr     (pi_addr),
        .pi_rw_b     (pi_rw_b),
        .pi_data_out (pi_data_out),
        .pi_data_in  (pi_data_in),
        .pi_pending  (pi_pending),
        .pi_done     (pi_done),
        .spi_busy    (spi_busy),
        .overrun     (overrun)
    );

    // Stand-in for main: records each request and completes the handshake.
    initial begin
        forever begin
            @(negedge clk16);
            if (resp_en && pi_pending === 1'b1 && pi_done === 1'b0) begin
                q_addr.push_back(pi_addr);
                q_rw.push_back(pi_rw_b);
                q_data.push_back(pi_data_out);
                repeat (resp_delay) @(negedge clk16);
                pi_data_in = resp_val;
                pi_done    = 1'b1;
                for (int k = 0; k < 50 && pi_pending === 1'b1; k++) @(negedge clk16);
                repeat (2) @(negedge clk16);
                pi_done    = 1'b0;
                pi_data_in = 8'($urandom);
            end
        end
    end

    task automatic clear_q();
        q_addr.delete();
        q_rw.delete();
        q_data.delete();
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk16);
    endtask

    task automatic spi_start();
        spi_cs_b = 1'b0;
        #(2.0 * SPI_HALF);
    endtask

    task automatic spi_end();
        #(SPI_HALF);
        spi_cs_b = 1'b1;
        #(2.0 * SPI_HALF);
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            #(SPI_HALF);
            rx[i] = spi_miso;
            spi_sclk = 1'b1;
            #(SPI_HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic send_frame();
        logic [7:0] rx;
        spi_start();
        for (int i = 0; i < frame_q.size(); i++) begin
            spi_byte(frame_q[i], rx);
            if (i == 0) first_rx = rx;
        end
        spi_end();
    endtask

    // Frame-level model: expected request and its effect on address / read data.
    task automatic model_frame(output logic [15:0] ea, output logic erw, output logic [7:0] ed);
        logic [1:0] c;
        c  = frame_q[0][7:6];
        ed = 8'h00;
        case (c)
            2'b00: begin m_addr = {frame_q[1], frame_q[2]}; ea = m_addr; erw = 1'b0; ed = frame_q[3]; end
            2'b01: begin m_addr = {frame_q[1], frame_q[2]}; ea = m_addr; erw = 1'b1; end
            2'b10: begin ea = m_addr; erw = 1'b0; ed = frame_q[1]; end
            default: begin ea = m_addr; erw = 1'b1; end
        endcase
        m_addr = m_addr + 16'd1;
        if (erw) m_rd = resp_val;
    endtask

    task automatic test_reset();
        settle(5);
        checks++; if ({pi_pending, pi_rw_b, pi_addr, pi_data_out, spi_miso, spi_busy, overrun} !== {1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            failures++; $display("FAIL reset_initial got pend=%b rw=%b addr=%h data=%h miso=%b busy=%b ovr=%b expected 0 1 0000 00 0 0 0",
                pi_pending, pi_rw_b, pi_addr, pi_data_out, spi_miso, spi_busy, overrun); end
        reset_b = 1'b1;
        settle(3);
        resp_en = 1'b0;
        frame_q = '{8'h00, 8'h12, 8'h34, 8'h56};
        send_frame();
        settle(10);
        checks++; if ({pi_pending, pi_addr, pi_rw_b, pi_data_out} !== {1'b1, 16'h1234, 1'b0, 8'h56}) begin
            failures++; $display("FAIL reset_pend_setup got pend=%b addr=%h rw=%b data=%h expected 1 1234 0 56", pi_pending, pi_addr, pi_rw_b, pi_data_out); end
        reset_b = 1'b0;
        #1;
        checks++; if ({pi_pending, pi_rw_b, pi_addr, pi_data_out, spi_miso, spi_busy, overrun} !== {1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            failures++; $display("FAIL reset_async got pend=%b rw=%b addr=%h data=%h miso=%b busy=%b ovr=%b expected 0 1 0000 00 0 0 0",
                pi_pending, pi_rw_b, pi_addr, pi_data_out, spi_miso, spi_busy, overrun); end
        settle(3);
        reset_b = 1'b1;
        settle(20);
        checks++; if (pi_pending !== 1'b0) begin
            failures++; $display("FAIL reset_after_release got pend=%b expected 0", pi_pending); end
        m_addr = 16'h0000;
        m_rd   = 8'h00;
    endtask

    task automatic test_write_at();
        clear_q();
        frame_q = '{8'h00, 8'hE8, 8'h0F, 8'h03};
        send_frame();
        settle(60);
        checks++; if (q_addr.size() !== 1) begin
            failures++; $display("FAIL write_at_count got %0d expected 1", q_addr.size()); end
        else begin
            checks++; if ({q_addr[0], q_rw[0], q_data[0]} !== {16'hE80F, 1'b0, 8'h03}) begin
                failures++; $display("FAIL write_at_req got addr=%h rw=%b data=%h expected E80F 0 03", q_addr[0], q_rw[0], q_data[0]); end
        end
        checks++; if ({spi_busy, pi_pending, pi_rw_b} !== 3'b001) begin
            failures++; $display("FAIL write_at_idle got busy=%b pend=%b rw=%b expected 0 0 1", spi_busy, pi_pending, pi_rw_b); end
        clear_q();
        resp_val = 8'h3C;
        frame_q = '{8'hC0};
        send_frame();
        settle(60);
        checks++; if (q_addr.size() !== 1 || q_addr[0] !== 16'hE810 || q_rw[0] !== 1'b1) begin
            failures++; $display("FAIL write_at_incr got n=%0d addr=%h expected 1 E810 read", q_addr.size(), (q_addr.size() > 0) ? q_addr[0] : 16'hxxxx); end
        m_addr = 16'hE811;
        m_rd   = 8'h3C;
    endtask

    task automatic test_read_at();
        clear_q();
        resp_val = 8'hA5;
        frame_q = '{8'h40, 8'h80, 8'h00};
        send_frame();
        settle(60);
        checks++; if (q_addr.size() !== 1 || q_addr[0] !== 16'h8000 || q_rw[0] !== 1'b1) begin
            failures++; $display("FAIL read_at_req got n=%0d addr=%h expected 1 8000 read", q_addr.size(), (q_addr.size() > 0) ? q_addr[0] : 16'hxxxx); end
        clear_q();
        frame_q = '{8'h00};
        send_frame();
        settle(20);
        checks++; if (first_rx !== 8'hA5) begin
            failures++; $display("FAIL read_at_miso got %h expected A5", first_rx); end
        checks++; if (q_addr.size() !== 0) begin
            failures++; $display("FAIL read_at_noreq got %0d requests expected 0", q_addr.size()); end
        m_addr = 16'h8001;
        m_rd   = 8'hA5;
    endtask

    task automatic test_auto_inc();
        clear_q();
        frame_q = '{8'h00, 8'hFF, 8'hFF, 8'h11};
        send_frame();
        settle(60);
        frame_q = '{8'h80, 8'h22};
        send_frame();
        settle(60);
        checks++; if (q_addr.size() !== 2) begin
            failures++; $display("FAIL auto_inc_count got %0d expected 2", q_addr.size()); end
        else begin
            checks++; if ({q_addr[0], q_rw[0], q_data[0]} !== {16'hFFFF, 1'b0, 8'h11}) begin
                failures++; $display("FAIL auto_inc_first got addr=%h rw=%b data=%h expected FFFF 0 11", q_addr[0], q_rw[0], q_data[0]); end
            checks++; if ({q_addr[1], q_rw[1], q_data[1]} !== {16'h0000, 1'b0, 8'h22}) begin
                failures++; $display("FAIL auto_inc_wrap got addr=%h rw=%b data=%h expected 0000 0 22", q_addr[1], q_rw[1], q_data[1]); end
        end
        m_addr = 16'h0001;
    endtask

    task automatic test_overrun();
        clear_q();
        resp_en = 1'b0;
        frame_q = '{8'hC0};
        send_frame();
        settle(20);
        checks++; if ({pi_pending, spi_busy, overrun, pi_addr} !== {1'b1, 1'b1, 1'b0, m_addr}) begin
            failures++; $display("FAIL overrun_first got pend=%b busy=%b ovr=%b addr=%h expected 1 1 0 %h", pi_pending, spi_busy, overrun, pi_addr, m_addr); end
        frame_q = '{8'hC3};
        send_frame();
        settle(20);
        checks++; if ({overrun, pi_pending, pi_addr} !== {1'b1, 1'b1, m_addr}) begin
            failures++; $display("FAIL overrun_set got ovr=%b pend=%b addr=%h expected 1 1 %h", overrun, pi_pending, pi_addr, m_addr); end
        spi_cs_b = 1'b0;
        settle(6);
        checks++; if (overrun !== 1'b0) begin
            failures++; $display("FAIL overrun_clear got %b expected 0", overrun); end
        spi_cs_b = 1'b1;
        settle(6);
        resp_val = 8'($urandom);
        resp_en  = 1'b1;
        settle(60);
        checks++; if (q_addr.size() !== 1 || q_addr[0] !== m_addr) begin
            failures++; $display("FAIL overrun_single got n=%0d expected 1 request to %h", q_addr.size(), m_addr); end
        m_addr = m_addr + 16'd1;
        m_rd   = resp_val;
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        clear_q();
        spi_start();
        spi_byte(8'h00, rx);
        spi_byte(m_addr[15:8], rx);
        for (int i = 7; i >= 3; i--) begin
            spi_mosi = 1'b1;
            #(SPI_HALF);
            spi_sclk = 1'b1;
            #(SPI_HALF);
            spi_sclk = 1'b0;
        end
        spi_end();
        settle(40);
        checks++; if (q_addr.size() !== 0) begin
            failures++; $display("FAIL abort_noreq got %0d requests expected 0", q_addr.size()); end
        frame_q = '{8'h80, 8'h5A};
        send_frame();
        settle(60);
        checks++; if (q_addr.size() !== 1 || {q_addr[0], q_rw[0], q_data[0]} !== {m_addr, 1'b0, 8'h5A}) begin
            failures++; $display("FAIL abort_next got n=%0d addr=%h expected 1 %h 0 5A", q_addr.size(), (q_addr.size() > 0) ? q_addr[0] : 16'hxxxx, m_addr); end
        m_addr = m_addr + 16'd1;
    endtask

    task automatic test_random();
        logic [15:0] ea;
        logic        erw;
        logic [7:0]  ed;
        logic [7:0]  exp_rx;
        int          nb;
        for (int it = 0; it < 12; it++) begin
            clear_q();
            frame_q.delete();
            frame_q.push_back({2'($urandom_range(0, 3)), 6'($urandom)});
            case (frame_q[0][7:6])
                2'b00:   nb = 3;
                2'b01:   nb = 2;
                2'b10:   nb = 1;
                default: nb = 0;
            endcase
            nb = nb + $urandom_range(0, 2);
            for (int j = 0; j < nb; j++) frame_q.push_back(8'($urandom));
            resp_val   = 8'($urandom);
            resp_delay = $urandom_range(0, 4);
            exp_rx     = m_rd;
            model_frame(ea, erw, ed);
            send_frame();
            settle(80);
            checks++; if (first_rx !== exp_rx) begin
                failures++; $display("FAIL random_miso it=%0d got %h expected %h", it, first_rx, exp_rx); end
            checks++; if (q_addr.size() !== 1) begin
                failures++; $display("FAIL random_count it=%0d got %0d expected 1", it, q_addr.size()); end
            else begin
                checks++; if (q_addr[0] !== ea || q_rw[0] !== erw || (!erw && q_data[0] !== ed)) begin
                    failures++; $display("FAIL random_req it=%0d got addr=%h rw=%b data=%h expected %h %b %h", it, q_addr[0], q_rw[0], q_data[0], ea, erw, ed); end
            end
            checks++; if (spi_busy !== 1'b0) begin
                failures++; $display("FAIL random_busy it=%0d got %b expected 0", it, spi_busy); end
        end
    endtask

    initial begin
        test_reset();
        resp_en = 1'b1;
        test_write_at();
        test_read_at();
        test_auto_inc();
        test_overrun();
        test_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pi_spi_bridge.md
# pi_spi_bridge

Converts SPI command frames from the Raspberry Pi into single-byte bus requests for the main bus timing. It drives the `pi_addr`, `pi_rw_b`, `pi_data` and `pi_pending` inputs of `main` and consumes `pi_done` and the read data that `main` returns. It sits in the FPGA top level, between the Pi's SPI pins and `main`. It replaces direct GPIO wiring of the 16-bit address and 8-bit data.

## Interface
- No parameters.
- `clk16`  in  1  16 MHz master clock; all logic on its rising edge.
- `reset_b`  in  1  asynchronous, active-low reset.
- `spi_sclk`  in  1  SPI clock, mode 0, max 4 MHz; asynchronous to `clk16`.
- `spi_cs_b`  in  1  SPI chip select, active low; asynchronous.
- `spi_mosi`  in  1  SPI data in; asynchronous.
- `spi_miso`  out  1  SPI data out.
- `pi_addr`  out  16  bus request address, to `main.pi_addr`.
- `pi_rw_b`  out  1  1 = read, 0 = write.
- `pi_data_out`  out  8  write data. The top level drives `pi_data` with this value when `pi_rw_b` = 0, and releases it otherwise.
- `pi_data_in`  in  8  read data from `main.pi_data`.
- `pi_pending`  out  1  request valid.
- `pi_done`  in  1  request complete, from `main`, in the `clk16` domain.
- `spi_busy`  out  1  a bus request is in flight. Routed to a Pi GPIO.
- `overrun`  out  1  sticky flag: a request was dropped.

## Operation
- **Input synchronisation**
  - `spi_sclk`, `spi_cs_b` and `spi_mosi` each pass through a 2-flop synchroniser.
  - Edge detection on the synchronised `spi_sclk` produces rise and fall strobes.
- **SPI mode 0**
  - MOSI is sampled on the SCLK rise; bytes are MSB first.
  - MISO changes on the SCLK fall.
  - The first MISO bit is valid within 3 clk cycles of `spi_cs_b` falling.
  - The tx shift register loads `rd_data` (the last read result) at `spi_cs_b` fall and after every 8th rise.
  - As a result, every byte shifted out equals the most recent read result at that byte's start.
- **Frame FSM** (states CMD, ADDR_HI, ADDR_LO, DATA, IGNORE), advancing on each completed byte:
  - The command is held in `cmd[7:6]`; `cmd[5:0]` is ignored.
  - `00` WRITE_AT: CMD → ADDR_HI → ADDR_LO → DATA. The write is issued after the DATA byte.
  - `01` READ_AT: CMD → ADDR_HI → ADDR_LO. The read is issued after ADDR_LO.
  - `10` WRITE_NEXT: CMD → DATA. The write uses the address register.
  - `11` READ_NEXT: the read is issued after CMD, using the address register.
  - After the request is issued, the FSM goes to IGNORE. Further bytes are discarded until `spi_cs_b` goes high.
  - `spi_cs_b` high at any point returns the FSM to CMD and clears the bit counter. Any partial byte is discarded.
  - An in-flight bus request is never aborted by `spi_cs_b`.
- **Address register**
  - 16 bits; ADDR_HI/ADDR_LO load bits [15:8] and [7:0].
  - Incremented by 1 when each request completes; wraps FFFF → 0000.
- **Bus FSM** (4-phase handshake, states B_IDLE, B_PEND, B_RELEASE):
  - B_IDLE: on a request strobe, latch `pi_addr`, `pi_rw_b` and `pi_data_out`, set `pi_pending` = 1, and go to B_PEND.
  - B_PEND: hold all outputs stable. When `pi_done` = 1:
    - if it is a read, capture `pi_data_in` into `rd_data`;
    - set `pi_pending` = 0, increment the address, and go to B_RELEASE.
  - B_RELEASE: when `pi_done` = 0, return `pi_rw_b` to 1 and go to B_IDLE.
  - `spi_busy` = (state ≠ B_IDLE).
- **Overrun**
  - A request strobe arriving while not in B_IDLE is dropped, and `overrun` is set.
  - `overrun` clears on a `spi_cs_b` falling edge or on reset.

## Timing
- Reset values, applied asynchronously and immediately, including mid-transaction:
  - `pi_pending` = 0, `pi_rw_b` = 1, `pi_addr` = 0000, `pi_data_out` = 00;
  - `spi_miso` = 0, `spi_busy` = 0, `overrun` = 0;
  - `rd_data` = 00, address register = 0000;
  - frame FSM = CMD, bus FSM = B_IDLE.
- The request strobe occurs 3 clk cycles after the SCLK rise of the final bit (2 for synchronisation, 1 for edge detection). `pi_pending` rises on the next clk edge.
- `pi_pending` falls 1 cycle after `pi_done` is sampled high. `rd_data` is valid in the same cycle.
- `spi_busy` falls 1 cycle after `pi_done` is sampled low.
- A read byte is returned on MISO only if the Pi starts the next byte after `spi_busy` = 0. Otherwise it gets the stale `rd_data`.
- Simultaneous `spi_cs_b` rise and final-bit rise: the byte is discarded and no request is issued.

## Test plan
- **Reset:** assert `reset_b` = 0 mid-B_PEND → all outputs return to reset values in the same cycle; after release, `pi_pending` stays 0.
- **WRITE_AT:** frame 00 E8 0F 03 at 2 MHz → a single request with `pi_addr` = E80F, `pi_rw_b` = 0, `pi_data_out` = 03; `pi_done` pulse → address register = E810.
- **READ_AT:** frame 40 80 00 with `main` returning A5 → `pi_rw_b` = 1, `pi_addr` = 8000; the next SPI byte (after `spi_busy` = 0) shifts out A5 on MISO.
- **Auto-increment:** WRITE_AT FFFF data 11, then WRITE_NEXT 22 → requests to FFFF then 0000.
- **Overrun:** hold `pi_done` = 0 and send READ_NEXT twice in separate frames → the second request is dropped, `overrun` = 1, and it clears on the next `spi_cs_b` fall.
- **Abort:** raise `spi_cs_b` after 5 bits of ADDR_LO → no request; the next frame 80 5A writes 5A to the previous address register value.
